// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC sequencing, branch/jump/jr target selection,
// single-pulse fetch completion, stall hold and a sticky misaligned-jr trap.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch,
  input  logic        zero_flag,
  input  logic        jump,
  input  logic        jr,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] rs_value,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  output logic        addr_err
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, ERROR} state_t;

  state_t      state;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] next_pc;
  logic        misaligned;

  assign pc_plus4      = pc + 32'd4;
  assign branch_target = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
  assign jump_target   = {pc_plus4[31:28], imm26, 2'b00};
  assign misaligned    = jr && (rs_value[1:0] != 2'b00);

  always_comb begin
    next_pc = pc_plus4;
    if (jr)
      next_pc = rs_value;
    else if (jump)
      next_pc = jump_target;
    else if (branch && zero_flag)
      next_pc = branch_target;
  end

  // Gated by reset so a request never appears while reset is held.
  assign imem_req = (state == FETCH) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      fetch_pc    <= RESET_PC;
      fetch_valid <= 1'b0;
      addr_err    <= 1'b0;
    end else begin
      fetch_valid <= 1'b0;
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (imem_ready) begin
            if (stall) begin
              fetch_pc    <= pc;
              fetch_valid <= 1'b1;
              state       <= HOLD;
            end else if (misaligned) begin
              addr_err <= 1'b1;
              pc       <= TRAP_PC;
              state    <= ERROR;
            end else begin
              pc          <= next_pc;
              fetch_pc    <= pc;
              fetch_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          // The held instruction already reported completion on HOLD entry.
          if (!stall) begin
            if (misaligned) begin
              addr_err <= 1'b1;
              pc       <= TRAP_PC;
              state    <= ERROR;
            end else begin
              pc    <= next_pc;
              state <= FETCH;
            end
          end
        end
        ERROR: state <= ERROR;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// run compared against a behavioural fetch model.
module tb_fetch_unit;

  localparam logic [31:0] RST = 32'h0000_0000;
  localparam logic [31:0] TRP = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch = 1'b0;
  logic        zero_flag = 1'b0;
  logic        jump = 1'b0;
  logic        jr = 1'b0;
  logic [15:0] imm16 = '0;
  logic [25:0] imm26 = '0;
  logic [31:0] rs_value = '0;
  logic        imem_ready = 1'b0;
  logic        imem_req;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        addr_err;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Behavioural model state
  logic [31:0] m_pc = RST;
  logic [31:0] m_fpc = RST;
  logic        m_fv = 1'b0;
  logic        m_err = 1'b0;
  logic        m_active = 1'b0;
  logic        m_hold = 1'b0;

  fetch_unit #(.RESET_PC(RST), .TRAP_PC(TRP)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch(branch),
    .zero_flag(zero_flag), .jump(jump), .jr(jr), .imm16(imm16),
    .imm26(imm26), .rs_value(rs_value), .imem_ready(imem_ready),
    .imem_req(imem_req), .pc(pc), .pc_plus4(pc_plus4),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_target(input logic [31:0] cur);
    logic [31:0] seq;
    int          off;
    seq = cur + 32'd4;
    off = $signed(imm16);
    if (jr) return rs_value;
    if (jump) return (seq & 32'hF000_0000) | (32'(imm26) * 32'd4);
    if (branch && zero_flag) return seq + 32'(off * 4);
    return seq;
  endfunction

  function automatic logic exp_req();
    return !reset && m_active && !m_hold && !m_err;
  endfunction

  task automatic model_step();
    logic bad_jr;
    bad_jr = jr && (rs_value % 4 != 0);
    if (reset) begin
      m_pc = RST; m_fpc = RST; m_fv = 1'b0; m_err = 1'b0;
      m_active = 1'b0; m_hold = 1'b0;
    end else if (m_err) begin
      m_fv = 1'b0;
    end else if (!m_active) begin
      m_active = 1'b1; m_fv = 1'b0;
    end else if (m_hold) begin
      m_fv = 1'b0;
      if (!stall) begin
        m_hold = 1'b0;
        if (bad_jr) begin m_err = 1'b1; m_pc = TRP; end
        else m_pc = ref_target(m_pc);
      end
    end else if (imem_ready) begin
      if (stall) begin
        m_fpc = m_pc; m_fv = 1'b1; m_hold = 1'b1;
      end else if (bad_jr) begin
        m_err = 1'b1; m_pc = TRP; m_fv = 1'b0;
      end else begin
        m_fpc = m_pc; m_fv = 1'b1; m_pc = ref_target(m_pc);
      end
    end else begin
      m_fv = 1'b0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    stall = 1'b0; branch = 1'b0; zero_flag = 1'b0; jump = 1'b0; jr = 1'b0;
    imm16 = '0; imm26 = '0; rs_value = '0;
  endtask

  task automatic go_fetch();
    clear_ctrl();
    imem_ready = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic jump_to(input logic [31:0] a);
    stall = 1'b0; imem_ready = 1'b1; jr = 1'b1; rs_value = a;
    tick();
    jr = 1'b0; rs_value = '0;
  endtask

  task automatic test_reset();
    clear_ctrl();
    reset = 1'b1;
    imem_ready = 1'b1;
    tick();
    tick();
    n_cmp++; if (pc !== RST) begin n_bad++; $display("FAIL reset_pc got %h exp %h", pc, RST); end
    n_cmp++; if (fetch_pc !== RST) begin n_bad++; $display("FAIL reset_fetch_pc got %h exp %h", fetch_pc, RST); end
    n_cmp++; if (fetch_valid !== 1'b0) begin n_bad++; $display("FAIL reset_fetch_valid got %b exp 0", fetch_valid); end
    n_cmp++; if (addr_err !== 1'b0) begin n_bad++; $display("FAIL reset_addr_err got %b exp 0", addr_err); end
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_imem_req got %b exp 0", imem_req); end
  endtask

  task automatic test_sequential();
    clear_ctrl();
    imem_ready = 1'b1;
    reset = 1'b0;
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL seq_idle_req got %b exp 0", imem_req); end
    tick();
    n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL seq_fetch_req got %b exp 1", imem_req); end
    n_cmp++; if (pc !== 32'h0) begin n_bad++; $display("FAIL seq_pc0 got %h exp 0", pc); end
    n_cmp++; if (fetch_valid !== 1'b0) begin n_bad++; $display("FAIL seq_fv0 got %b exp 0", fetch_valid); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (pc !== 32'(4 * (i + 1))) begin n_bad++; $display("FAIL seq_pc got %h exp %h", pc, 32'(4 * (i + 1))); end
      n_cmp++; if (fetch_valid !== 1'b1) begin n_bad++; $display("FAIL seq_fv got %b exp 1", fetch_valid); end
      n_cmp++; if (fetch_pc !== 32'(4 * i)) begin n_bad++; $display("FAIL seq_fetch_pc got %h exp %h", fetch_pc, 32'(4 * i)); end
    end
  endtask

  task automatic test_branch();
    go_fetch();
    jump_to(32'h100);
    branch = 1'b1; zero_flag = 1'b1; imm16 = 16'hFFFE;
    tick();
    n_cmp++; if (pc !== 32'hFC) begin n_bad++; $display("FAIL branch_taken got %h exp %h", pc, 32'hFC); end
    clear_ctrl();
    jump_to(32'h100);
    branch = 1'b1; zero_flag = 1'b0; imm16 = 16'hFFFE;
    tick();
    n_cmp++; if (pc !== 32'h104) begin n_bad++; $display("FAIL branch_not_taken got %h exp %h", pc, 32'h104); end
    clear_ctrl();
  endtask

  task automatic test_priority();
    go_fetch();
    jump_to(32'h4000_0010);
    jump = 1'b1; imm26 = 26'h0000040; branch = 1'b1; zero_flag = 1'b1; imm16 = 16'h0010;
    tick();
    n_cmp++; if (pc !== 32'h4000_0100) begin n_bad++; $display("FAIL jump_over_branch got %h exp %h", pc, 32'h4000_0100); end
    jr = 1'b1; rs_value = 32'h200;
    tick();
    n_cmp++; if (pc !== 32'h200) begin n_bad++; $display("FAIL jr_over_jump got %h exp %h", pc, 32'h200); end
    clear_ctrl();
  endtask

  task automatic test_misaligned();
    go_fetch();
    jr = 1'b1; rs_value = 32'h203;
    tick();
    n_cmp++; if (addr_err !== 1'b1) begin n_bad++; $display("FAIL trap_addr_err got %b exp 1", addr_err); end
    n_cmp++; if (pc !== TRP) begin n_bad++; $display("FAIL trap_pc got %h exp %h", pc, TRP); end
    n_cmp++; if (fetch_valid !== 1'b0) begin n_bad++; $display("FAIL trap_fv got %b exp 0", fetch_valid); end
    for (int i = 0; i < 3; i++) begin
      jr = 1'b0; jump = 1'($urandom); imm26 = 26'($urandom); stall = 1'($urandom);
      tick();
      n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL err_req got %b exp 0", imem_req); end
      n_cmp++; if (pc !== TRP || addr_err !== 1'b1) begin n_bad++; $display("FAIL err_hold got pc=%h err=%b exp pc=%h err=1", pc, addr_err, TRP); end
      n_cmp++; if (fetch_valid !== 1'b0) begin n_bad++; $display("FAIL err_fv got %b exp 0", fetch_valid); end
    end
    clear_ctrl();
    reset = 1'b1;
    tick();
    n_cmp++; if (addr_err !== 1'b0 || pc !== RST) begin n_bad++; $display("FAIL err_reset got pc=%h err=%b exp pc=%h err=0", pc, addr_err, RST); end
    reset = 1'b0;
  endtask

  task automatic test_stall_wrap();
    go_fetch();
    jump_to(32'h20);
    stall = 1'b1; imem_ready = 1'b1;
    tick();
    n_cmp++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h20) begin n_bad++; $display("FAIL stall_pulse got fv=%b fpc=%h exp fv=1 fpc=%h", fetch_valid, fetch_pc, 32'h20); end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (fetch_valid !== 1'b0) begin n_bad++; $display("FAIL stall_no_repulse got %b exp 0", fetch_valid); end
      n_cmp++; if (pc !== 32'h20 || imem_req !== 1'b0) begin n_bad++; $display("FAIL stall_hold got pc=%h req=%b exp pc=%h req=0", pc, imem_req, 32'h20); end
    end
    stall = 1'b0;
    tick();
    n_cmp++; if (pc !== 32'h24 || imem_req !== 1'b1 || fetch_valid !== 1'b0) begin n_bad++; $display("FAIL stall_release got pc=%h req=%b fv=%b exp pc=%h req=1 fv=0", pc, imem_req, fetch_valid, 32'h24); end
    jump_to(32'hFFFF_FFFC);
    n_cmp++; if (pc_plus4 !== 32'h0) begin n_bad++; $display("FAIL wrap_plus4 got %h exp 0", pc_plus4); end
    tick();
    n_cmp++; if (pc !== 32'h0) begin n_bad++; $display("FAIL wrap_pc got %h exp 0", pc); end
  endtask

  task automatic test_reset_mid();
    go_fetch();
    jump_to(32'h300);
    imem_ready = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL mid_reset_req got %b exp 0", imem_req); end
    tick();
    reset = 1'b0;
    #1;
    n_cmp++; if (pc !== RST || fetch_valid !== 1'b0) begin n_bad++; $display("FAIL mid_reset_state got pc=%h fv=%b exp pc=%h fv=0", pc, fetch_valid, RST); end
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL mid_reset_idle got %b exp 0", imem_req); end
    tick();
    n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL mid_reset_fetch got %b exp 1", imem_req); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset      = ($urandom_range(0, 39) == 0);
      stall      = ($urandom_range(0, 3) == 0);
      imem_ready = ($urandom_range(0, 3) != 0);
      branch     = ($urandom_range(0, 2) == 0);
      zero_flag  = 1'($urandom);
      jump       = ($urandom_range(0, 5) == 0);
      jr         = ($urandom_range(0, 7) == 0);
      imm16      = 16'($urandom);
      imm26      = 26'($urandom);
      rs_value   = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) rs_value[1:0] = 2'($urandom_range(1, 3));
      #1;
      n_cmp++; if (imem_req !== exp_req()) begin n_bad++; $display("FAIL rnd_req cyc %0d got %b exp %b", i, imem_req, exp_req()); end
      n_cmp++; if (pc_plus4 !== m_pc + 32'd4) begin n_bad++; $display("FAIL rnd_plus4 cyc %0d got %h exp %h", i, pc_plus4, m_pc + 32'd4); end
      tick();
      n_cmp++; if (pc !== m_pc) begin n_bad++; $display("FAIL rnd_pc cyc %0d got %h exp %h", i, pc, m_pc); end
      n_cmp++; if (fetch_valid !== m_fv) begin n_bad++; $display("FAIL rnd_fv cyc %0d got %b exp %b", i, fetch_valid, m_fv); end
      n_cmp++; if (m_fv && fetch_pc !== m_fpc) begin n_bad++; $display("FAIL rnd_fetch_pc cyc %0d got %h exp %h", i, fetch_pc, m_fpc); end
      n_cmp++; if (addr_err !== m_err) begin n_bad++; $display("FAIL rnd_addr_err cyc %0d got %b exp %b", i, addr_err, m_err); end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_priority();
    test_misaligned();
    test_stall_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
